// File: rtl/alu_sched.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Operands are held for a per-opcode number of cycles before the result is captured.
module alu_sched #(
  parameter int unsigned FLOAT_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [4:0]  alu_op,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  input  logic        rsp_ready
);

  localparam logic [3:0] FloatCnt = 4'(FLOAT_LAT - 1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [4:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_in1_q, alu_in1_d;
  logic [15:0] alu_in2_q, alu_in2_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_data_q, rsp_data_d;

  logic        grant;
  logic        accept;
  logic [4:0]  sel_op;
  logic [15:0] sel_a, sel_b;

  function automatic logic is_float(input logic [4:0] op);
    case (op)
      5'h01, 5'h02, 5'h03, 5'h0A, 5'h0B: is_float = 1'b1;
      default:                           is_float = 1'b0;
    endcase
  endfunction

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end
    req0_ready = (state_q == StIdle) && req0_valid && !grant && reset;
    req1_ready = (state_q == StIdle) && req1_valid && grant && reset;
    accept     = req0_ready | req1_ready;
    sel_op     = grant ? req1_op : req0_op;
    sel_a      = grant ? req1_a  : req0_a;
    sel_b      = grant ? req1_b  : req0_b;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    alu_op_d     = alu_op_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          alu_op_d     = sel_op;
          alu_in1_d    = sel_a;
          alu_in2_d    = sel_b;
          rsp_id_d     = grant;
          last_grant_d = grant;
          cnt_d        = is_float(sel_op) ? FloatCnt : 4'd0;
          state_d      = StExec;
        end
      end
      StExec: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_data_d  = alu_result;
          rsp_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      alu_op_q     <= 5'd0;
      alu_in1_q    <= 16'd0;
      alu_in2_q    <= 16'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_op_q     <= alu_op_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: stimulus pushes hand-computed responses,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  alu_op;
  logic [15:0] alu_in1, alu_in2, alu_result;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [15:0] rsp_data;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  logic [16:0] exp_q[$];

  alu_sched #(.FLOAT_LAT(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the alu: add, xor, bfloat16 int-to-float, passthrough.
  function automatic logic [15:0] alu_model(input logic [4:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    int msb;
    logic [15:0] m;
    case (op)
      5'h00: alu_model = a + b;
      5'h04: alu_model = a ^ b;
      5'h0B: begin
        msb = 0;
        for (int i = 0; i < 16; i++) if (a[i]) msb = i;
        m = 16'(a << (15 - msb));
        alu_model = (a == 16'd0) ? 16'd0 : {1'b0, 8'(127 + msb), m[14:8]};
      end
      default: alu_model = a;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_in1, alu_in2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every response handshake must match the oldest expected entry.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e[16]));
          check("rsp_data", 32'(rsp_data), 32'(e[15:0]));
        end
      end
    end
  end

  task automatic drive(input logic id, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic v);
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = v;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = v;
    end
  endtask

  // Issues one op, waits for its response, checks latency and operand hold.
  task automatic run_op(input logic id, input logic [4:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_data, input int exp_lat);
    int   acc;
    logic seen, stable;
    @(posedge clk); #1;
    drive(id, op, a, b, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = id ? req1_ready : req0_ready;
    end
    check("accept_ready", 32'(seen), 32'd1);
    exp_q.push_back({id, exp_data});
    acc = cyc + 1;
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    seen = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
      if (alu_op !== op || alu_in1 !== a || alu_in2 !== b) stable = 1'b0;
    end
    check("rsp_latency", 32'(cyc - acc), 32'(exp_lat));
    check("alu_hold", 32'(stable), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        g, stable, quiet;
    logic [15:0] d0;

    // Reset with both requesters asserting.
    reset = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b0, 5'h00, 16'h0010, 16'h0020, 1'b1);
    drive(1'b1, 5'h00, 16'h0100, 16'h0200, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_in1", 32'(alu_in1), 32'd0);
    check("rst_alu_in2", 32'(alu_in2), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("first_tie_req0", 32'(req0_ready), 32'd1);
    check("first_tie_req1", 32'(req1_ready), 32'd0);
    exp_q.push_back({1'b0, 16'h0030});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // Integer add, then confirm return to idle one cycle after the response.
    run_op(1'b0, 5'h00, 16'h0003, 16'h0004, 16'h0007, 1);
    drive(1'b0, 5'h00, 16'h0000, 16'h0000, 1'b1);
    #1;
    check("done_no_accept", 32'(req0_ready), 32'd0);
    @(negedge clk);
    check("idle_after_done", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0;
    drain();

    // Float i2f holds operands for three cycles.
    run_op(1'b1, 5'h0B, 16'h0001, 16'h0000, 16'h3F80, 3);
    drain();

    // Contention: grants alternate starting with requester 0.
    @(posedge clk); #1;
    drive(1'b0, 5'h04, 16'h00FF, 16'h0F0F, 1'b1);
    drive(1'b1, 5'h04, 16'hFFFF, 16'h0001, 1'b1);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 20 && !(req0_ready || req1_ready); i++) @(negedge clk);
      g = req1_ready;
      check("rr_grant", 32'(g), 32'(k % 2));
      check("rr_onehot", 32'(req0_ready & req1_ready), 32'd0);
      exp_q.push_back((k % 2 == 0) ? {1'b0, 16'h0FF0} : {1'b1, 16'hFFFE});
      @(posedge clk); #1;
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
    end
    drain();

    // Backpressure: response held for five cycles with both requesters waiting.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    run_op(1'b0, 5'h00, 16'h1234, 16'h1111, 16'h2345, 1);
    drive(1'b0, 5'h00, 16'h0000, 16'h0000, 1'b1);
    drive(1'b1, 5'h00, 16'h0005, 16'h0006, 1'b1);
    d0 = rsp_data;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 16'h2345 || rsp_id !== 1'b0 || d0 !== rsp_data ||
          req0_ready || req1_ready) stable = 1'b0;
    end
    check("bp_hold", 32'(stable), 32'd1);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_before_edge", 32'(rsp_valid), 32'd1);
    check("bp_no_accept_in_done", 32'(req1_ready), 32'd0);
    @(negedge clk);
    check("bp_valid_dropped", 32'(rsp_valid), 32'd0);
    check("bp_accept_reenabled", 32'(req1_ready), 32'd1);
    exp_q.push_back({1'b1, 16'h000B});
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();

    // Abort: reset during a float op drops it without a response.
    @(posedge clk); #1;
    drive(1'b0, 5'h02, 16'h4000, 16'h4000, 1'b1);
    for (int i = 0; i < 20 && !req0_ready; i++) @(negedge clk);
    check("abort_accept", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_alu_op", 32'(alu_op), 32'd0);
    check("abort_alu_in1", 32'(alu_in1), 32'd0);
    check("abort_alu_in2", 32'(alu_in2), 32'd0);
    check("abort_rsp_id", 32'(rsp_id), 32'd0);
    check("abort_rsp_data", 32'(rsp_data), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) quiet = 1'b0;
      if (i == 1) begin
        @(posedge clk); #1;
        reset = 1'b1;
      end
    end
    check("abort_no_rsp", 32'(quiet), 32'd1);
    run_op(1'b1, 5'h00, 16'h0002, 16'h0003, 16'h0005, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
